// File: rtl/vec_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one vector-FIFO write port among NUM_REQ requesters.
// A granted requester keeps the port until it transfers a beat flagged last.
//
// state | meaning
// IDLE  | no owner; pick the next requester after last_grant, accept no beat
// BUSY  | grant_id owns the write port until its last beat transfers
module vec_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_write,
    output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
    output logic                          o_grant_valid,
    output logic [ID_WIDTH-1:0]           o_grant_id
);

    if (ID_WIDTH != $clog2(NUM_REQ)) begin : g_bad_id_width
        $error("vec_fifo_wr_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic                  r_grant_valid;

    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_busy;
    logic                  w_transfer;
    logic [NUM_REQ-1:0]    w_ready;

    // Search upward from last_grant+1 with wrap; the first hit wins.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && i_req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == r_grant_id) begin
                w_sel_valid = i_req_valid[i];
                w_sel_last  = i_req_last[i];
                w_sel_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_busy     = (r_state == BUSY);
    // Ready gated by full, so the FIFO can never be written while full.
    assign w_transfer = w_busy && w_sel_valid && !i_fifo_full;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_busy && (ID_WIDTH'(i) == r_grant_id)) begin
                w_ready[i] = !i_fifo_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_last_grant  <= ID_WIDTH'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_id    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_transfer && w_sel_last) begin
                        r_last_grant  <= r_grant_id;
                        r_grant_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready    = w_ready;
    assign o_fifo_write   = w_transfer;
    assign o_fifo_wr_data = w_busy ? w_sel_data : '0;
    assign o_grant_valid  = r_grant_valid;
    assign o_grant_id     = r_grant_id;

endmodule

// File: doc/vec_fifo_wr_arbiter.md
Name: vec_fifo_wr_arbiter

Overview:
- Shares one write port of a vector-unit FIFO between NUM_REQ requesters (lane/load units).
- Round-robin arbitration with packet lock: once granted, a requester owns the FIFO write port until it transfers a beat flagged last.
- Sits directly in front of the FIFO write side, drives its write strobe and data, and honours its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, width of one FIFO entry.
- ID_WIDTH, 2, width of grant_id; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_last  input  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req_valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester beat accept (one-hot or zero).
- fifo_full  input  1  FIFO full flag.
- fifo_write  output  1  FIFO write strobe.
- fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- grant_valid  output  1  a requester currently owns the port.
- grant_id  output  ID_WIDTH  index of the owning requester.

Behaviour:
- Reset (rst low, async): state IDLE; last_grant = NUM_REQ-1, so requester 0 has top priority after reset; grant_valid=0; grant_id=0; req_ready=0; fifo_write=0; fifo_wr_data=0.
- FSM states are IDLE and BUSY.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from last_grant+1, with wrap-around modulo NUM_REQ.
  - Register the winner in grant_id, set grant_valid=1, and go to BUSY on the next edge.
  - No beat is accepted in IDLE, giving a 1-cycle arbitration latency.
  - If no request, stay in IDLE.
- BUSY, with g = grant_id:
  - req_ready[g] = !fifo_full. All other ready bits are 0. Ready is combinational from fifo_full and state.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - fifo_write = transfer (combinational); fifo_wr_data = req_data[g] whenever BUSY, 0 in IDLE.
  - Transfer with req_last[g]=1: on the next edge go to IDLE, last_grant <= g, grant_valid <= 0.
  - Transfer with req_last[g]=0, or no transfer: stay in BUSY.
  - The requester may drop req_valid mid-packet; the lock is held regardless (bubbles allowed).
- Never assert fifo_write while fifo_full=1.
- Requester obligation: once req_valid is asserted it is held, with data and last stable, until the beat transfers. Checked by the bench, not by RTL.
- A single-beat packet (last on first beat) takes 2 cycles per grant: 1 arbitrate + 1 transfer. Back-to-back packets from different requesters therefore have a 1-cycle IDLE gap.
- Requests arriving in BUSY from non-owners wait. They are considered at the next IDLE cycle using the updated last_grant.
- req_valid/req_last of non-granted requesters do not affect outputs.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned; the FIFO is expected to be reset by the same rst.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,...,NUM_REQ-1,0,...

Test Plan:
- Reset then idle: rst low 3 cycles, all req_valid=0 → grant_valid=0, req_ready=0, fifo_write=0, fifo_wr_data=0 throughout; stays IDLE.
- Single requester, 3-beat packet from req2 (data 0xA,0xB,0xC; last on 0xC), fifo_full=0 → grant_id=2 one cycle after req_valid; fifo_write high 3 consecutive cycles with 0xA,0xB,0xC; grant_valid drops the cycle after 0xC.
- All 4 requesters valid with 1-beat packets, repeated → grant_id sequence 0,1,2,3,0 with a transfer every 2nd cycle.
- Backpressure: req1 granted, fifo_full=1 for 4 cycles mid-packet → req_ready[1]=0 and fifo_write=0 during those cycles; beat held; transfer resumes the cycle fifo_full falls; no beat lost or duplicated.
- Lock hold: req0 granted, drops req_valid 2 cycles mid-packet while req3 is valid → grant stays 0; req3 granted only after req0's last beat plus 1 IDLE cycle.
- Async reset mid-packet: rst low between edges during BUSY → all outputs reach reset values immediately; after release with req1 and req0 valid, req0 is granted first (last_grant restored to NUM_REQ-1).
